// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadows the time digits, scans them
// with an all-off gap before each digit, and takes new digits only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    lzb_en_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
  output logic                    load_ack_o,
  output logic [3:0]              bcd_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    seg_blank_o,
  output logic                    frame_done_o
);

  localparam int unsigned IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CMAX   = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW     = $clog2(CMAX + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    ack_q, ack_d;
  logic                    fdone_q, fdone_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    blank_q, blank_d;
  logic                    last_dwell;
  logic                    capture;

  function automatic logic [3:0] nib(input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] k);
    int unsigned base;
    base = 4 * (NUM_DIGITS - 1 - 32'(k));
    return v[base +: 4];
  endfunction

  // Digit k is blanked when it and every digit to its left are zero; the last digit never is.
  function automatic logic lzb_blank(input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] k);
    logic all_zero;
    all_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      if (j <= 32'(k) && nib(v, IW'(j)) != 4'd0) all_zero = 1'b0;
    end
    return (32'(k) < NUM_DIGITS - 1) && all_zero;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    fdone_d    = 1'b0;
    last_dwell = (state_q == S_SHOW) && (cnt_q == DWELL_END);
    capture    = load_i && !ack_q &&
                 ((state_q == S_IDLE) || (last_dwell && idx_q == LAST_IDX));
    ack_d      = capture;
    if (capture) shadow_d = digits_i;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BLANK: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_END) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (last_dwell) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            fdone_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from next-state values so the registered outputs line up with the state.
    bcd_d   = nib(shadow_d, idx_d);
    sel_d   = (state_d == S_SHOW) ? (NUM_DIGITS'(1) << idx_d) : '0;
    blank_d = (state_d != S_SHOW) || (lzb_en_i && lzb_blank(shadow_d, idx_d));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      fdone_q  <= 1'b0;
      bcd_q    <= '0;
      sel_q    <= '0;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      fdone_q  <= fdone_d;
      bcd_q    <= bcd_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
    end
  end

  assign load_ack_o   = ack_q;
  assign frame_done_o = fdone_q;
  assign bcd_o        = bcd_q;
  assign digit_sel_o  = sel_q;
  assign seg_blank_o  = blank_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a frame-position reference model pushes the
// expected outputs for every clock edge; a monitor pops and compares them on the falling edge.
module tb_seven_seg_scan_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned BL = 2;
  localparam int unsigned SLOT  = BL + DW;
  localparam int unsigned FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          lzb = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic          load = 1'b0;
  logic          load_ack_o;
  logic [3:0]    bcd_o;
  logic [N-1:0]  digit_sel_o;
  logic          seg_blank_o;
  logic          frame_done_o;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .lzb_en_i(lzb), .digits_i(digits),
    .load_i(load), .load_ack_o(load_ack_o), .bcd_o(bcd_o), .digit_sel_o(digit_sel_o),
    .seg_blank_o(seg_blank_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   bcd;
    logic [N-1:0] sel;
    logic         blank;
    logic         ack;
    logic         fd;
    logic         bcd_care;
  } exp_t;

  exp_t q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model: position within the frame, counted from the first blank cycle of digit 0.
  bit          m_run = 1'b0;
  int unsigned m_t = 0;
  logic [15:0] m_sh = '0;
  bit          m_ack = 1'b0;

  task automatic model_edge();
    exp_t        e;
    bit          cap, fd, show;
    int unsigned d;
    logic [15:0] hi;
    fd = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_sh = '0; m_ack = 1'b0;
    end else begin
      cap = load && !m_ack && (!m_run || m_t == FRAME - 1);
      if (cap) m_sh = digits;
      m_ack = cap;
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_t = 0; end
      end else if (!en) begin
        m_run = 1'b0;
      end else begin
        m_t = (m_t + 1) % FRAME;
        fd  = (m_t == 0);
      end
    end
    e.ack = m_ack;
    e.fd  = fd;
    if (m_run) begin
      d    = m_t / SLOT;
      show = (m_t % SLOT) >= BL;
      hi   = m_sh >> (4 * (N - 1 - d));
      e.bcd      = hi[3:0];
      e.bcd_care = 1'b1;
      e.sel      = show ? N'(1 << d) : '0;
      e.blank    = !show || (lzb && d < N - 1 && hi == 16'd0);
    end else begin
      e.bcd = '0; e.bcd_care = 1'b0; e.sel = '0; e.blank = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic timeout_fail(input string what);
    n_chk++;
    $display("FAIL %s: no event within bound at %0t, required within 100 cycles", what, $time);
  endtask

  task automatic wait_phase(input int unsigned tt);
    int unsigned k = 0;
    while (!(m_run && m_t == tt) && k < 100) begin step(); k++; end
    if (k >= 100) timeout_fail("wait_phase");
  endtask

  task automatic do_load(input logic [15:0] v, input int unsigned hold);
    int unsigned k = 0;
    load = 1'b1; digits = v;
    step();
    while (load_ack_o !== 1'b1 && k < 100) begin step(); k++; end
    if (k >= 100) timeout_fail("load_ack");
    else repeat (hold) step();
    load = 1'b0; digits = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ((!e.bcd_care || bcd_o === e.bcd) && digit_sel_o === e.sel && seg_blank_o === e.blank &&
          load_ack_o === e.ack && frame_done_o === e.fd)
        n_pass++;
      else
        $display("FAIL outputs at %0t: got bcd=%h sel=%b blank=%b ack=%b fd=%b, required bcd=%h%s sel=%b blank=%b ack=%b fd=%b",
                 $time, bcd_o, digit_sel_o, seg_blank_o, load_ack_o, frame_done_o,
                 e.bcd, e.bcd_care ? "" : "(dc)", e.sel, e.blank, e.ack, e.fd);
    end
  end

  initial begin
    run(3);
    rst = 1'b0;
    run(2);

    // Load in IDLE, then scan a few frames.
    do_load(16'h1234, 0);
    en = 1'b1;
    run(60);

    // Request raised during digit 1 SHOW waits for the frame boundary.
    wait_phase(2 * SLOT - SLOT + BL);
    do_load(16'h5678, 0);
    run(30);

    // Leading-zero blanking patterns.
    lzb = 1'b1;
    do_load(16'h0005, 0); run(30);
    do_load(16'h0000, 0); run(30);
    do_load(16'h0A05, 0); run(30);

    // Drop enable during digit 2 SHOW, then re-enable.
    wait_phase(2 * SLOT + BL + 1);
    en = 1'b0; run(3);
    en = 1'b1; run(30);

    // Hold load three cycles past the ack.
    do_load(16'h9876, 3);
    run(30);

    // Reset asserted during the ack cycle.
    begin
      int unsigned k = 0;
      load = 1'b1; digits = 16'h4321;
      step();
      while (load_ack_o !== 1'b1 && k < 100) begin step(); k++; end
      if (k >= 100) timeout_fail("rst_ack");
      rst = 1'b1; load = 1'b0;
      step();
      rst = 1'b0;
      run(30);
    end

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: do_load(rand_digits(), $urandom_range(0, 2));
        1: lzb = 1'($urandom);
        2: begin en = 1'b0; run($urandom_range(1, 5)); en = 1'b1; end
        3: run($urandom_range(1, 30));
        default: if ($urandom_range(0, 3) == 0) begin rst = 1'b1; step(); rst = 1'b0; end
      endcase
    end
    run(30);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
